audio_in_detect: RTL and testbench



---
 rtl/audio_in_detect_pkg.sv | 31 +++
 rtl/audio_in_detect_if.sv | 44 ++++
 rtl/audio_abs_sat.sv | 27 ++
 rtl/audio_in_detect.sv | 129 ++++++++++++
 tb/tb_audio_in_detect.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_in_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_in_detect_pkg
// Brief    : Shared audio constants, capture FSM encoding and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package audio_in_detect_pkg;

    localparam int c_SAMPLE_W = 32;
    localparam int c_MAG_W    = 16;

    // Default detector thresholds, also used by the beep path.
    localparam logic [c_MAG_W-1:0] c_THRESH_ON_DEF     = 16'h2000;
    localparam logic [c_MAG_W-1:0] c_THRESH_OFF_DEF    = 16'h1000;
    localparam int                 c_QUIET_SAMPLES_DEF = 4800;
    localparam int                 c_CNT_W_DEF         = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_CALC   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    function automatic logic [c_MAG_W-1:0] mag_max(input logic [c_MAG_W-1:0] a,
                                                   input logic [c_MAG_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_in_detect_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_in_detect_if
// Brief    : Codec input FIFO handshake plus detector result signals.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_in_detect_if;
    import audio_in_detect_pkg::*;

    logic                  audio_in_available;
    logic [c_SAMPLE_W-1:0] left_channel_audio_in;
    logic [c_SAMPLE_W-1:0] right_channel_audio_in;
    logic                  read_audio_in;
    logic                  sample_valid;
    logic [c_MAG_W-1:0]    mag_out;
    logic                  sound_active;
    logic                  sound_event;

    // Audio controller / consumer side
    modport master (
        output audio_in_available,
        output left_channel_audio_in,
        output right_channel_audio_in,
        input  read_audio_in,
        input  sample_valid,
        input  mag_out,
        input  sound_active,
        input  sound_event
    );

    // Detector side
    modport slave (
        input  audio_in_available,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        output read_audio_in,
        output sample_valid,
        output mag_out,
        output sound_active,
        output sound_event
    );

endinterface
`default_nettype wire

// File: rtl/audio_abs_sat.sv
`default_nettype none
// ============================================================================
// Module   : audio_abs_sat
// Brief    : Signed 16-bit to unsigned magnitude, -32768 clamps to 32767.
// Revision : 1.0 - initial release
// ============================================================================
module audio_abs_sat
    import audio_in_detect_pkg::*;
(
    input  logic [c_MAG_W-1:0] i_sample,
    output logic [c_MAG_W-1:0] o_mag
);

    localparam logic [c_MAG_W-1:0] c_MOST_NEG = 16'h8000;
    localparam logic [c_MAG_W-1:0] c_MOST_POS = 16'h7FFF;

    always_comb begin
        o_mag = i_sample;
        if (i_sample == c_MOST_NEG) begin
            o_mag = c_MOST_POS;
        end else if (i_sample[c_MAG_W-1]) begin
            o_mag = ~i_sample + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_in_detect.sv
`default_nettype none
// ============================================================================
// Module   : audio_in_detect
// Brief    : Drains L/R ADC pairs, computes magnitude, hysteresis sound detect.
// Revision : 1.0 - initial release
// ============================================================================
module audio_in_detect
    import audio_in_detect_pkg::*;
#(
    parameter logic [c_MAG_W-1:0] THRESH_ON     = c_THRESH_ON_DEF,
    parameter logic [c_MAG_W-1:0] THRESH_OFF    = c_THRESH_OFF_DEF,
    parameter int                 QUIET_SAMPLES = c_QUIET_SAMPLES_DEF,
    parameter int                 CNT_W         = c_CNT_W_DEF
)(
    input  logic           CLOCK_50,
    input  logic           reset,
    audio_in_detect_if.slave bus
);

    localparam logic [CNT_W-1:0] c_QUIET_LIMIT = CNT_W'(QUIET_SAMPLES);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_read;

    logic [c_MAG_W-1:0] r_left;
    logic [c_MAG_W-1:0] r_right;
    logic [c_MAG_W-1:0] w_abs_left;
    logic [c_MAG_W-1:0] w_abs_right;
    logic [c_MAG_W-1:0] r_mag_calc;
    logic [c_MAG_W-1:0] r_mag_out;
    logic               r_valid;
    logic               r_active;
    logic               r_event;
    logic [CNT_W-1:0]   r_quiet_cnt;
    logic [CNT_W-1:0]   w_quiet_inc;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fixed four-state loop keeps pops at least three cycles apart.
    always_comb begin
        w_state_next = r_state;
        w_read       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.audio_in_available) begin
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                w_read       = 1'b1;
                w_state_next = ST_CALC;
            end
            ST_CALC:   w_state_next = ST_UPDATE;
            ST_UPDATE: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    audio_abs_sat u_abs_left (
        .i_sample (r_left),
        .o_mag    (w_abs_left)
    );

    audio_abs_sat u_abs_right (
        .i_sample (r_right),
        .o_mag    (w_abs_right)
    );

    assign w_quiet_inc = r_quiet_cnt + CNT_W'(1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_left      <= '0;
            r_right     <= '0;
            r_mag_calc  <= '0;
            r_mag_out   <= '0;
            r_valid     <= 1'b0;
            r_active    <= 1'b0;
            r_event     <= 1'b0;
            r_quiet_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            r_event <= 1'b0;
            if (r_state == ST_READ) begin
                r_left  <= bus.left_channel_audio_in[c_SAMPLE_W-1 -: c_MAG_W];
                r_right <= bus.right_channel_audio_in[c_SAMPLE_W-1 -: c_MAG_W];
            end
            if (r_state == ST_CALC) begin
                r_mag_calc <= mag_max(w_abs_left, w_abs_right);
            end
            if (r_state == ST_UPDATE) begin
                r_mag_out <= r_mag_calc;
                r_valid   <= 1'b1;
                if (!r_active) begin
                    if (r_mag_calc >= THRESH_ON) begin
                        r_active    <= 1'b1;
                        r_event     <= 1'b1;
                        r_quiet_cnt <= '0;
                    end
                end else if (r_mag_calc < THRESH_OFF) begin
                    // Release only after an unbroken run of quiet samples.
                    if (w_quiet_inc == c_QUIET_LIMIT) begin
                        r_active    <= 1'b0;
                        r_quiet_cnt <= '0;
                    end else begin
                        r_quiet_cnt <= w_quiet_inc;
                    end
                end else begin
                    r_quiet_cnt <= '0;
                end
            end
        end
    end

    assign bus.read_audio_in = w_read;
    assign bus.sample_valid  = r_valid;
    assign bus.mag_out       = r_mag_out;
    assign bus.sound_active  = r_active;
    assign bus.sound_event   = r_event;

endmodule
`default_nettype wire

// File: tb/tb_audio_in_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_in_detect
// Brief    : Directed self-checking bench for audio_in_detect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_in_detect;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    audio_in_detect_if bus();

    audio_in_detect dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int   n_cmp     = 0;
    int   n_err     = 0;
    int   ev_cnt    = 0;
    int   dbl_read  = 0;
    int   orphan_ev = 0;
    logic prev_read = 1'b0;

    always @(negedge CLOCK_50) begin
        if (bus.sound_event) ev_cnt++;
        if (bus.sound_event && !bus.sample_valid) orphan_ev++;
        if (bus.read_audio_in && prev_read) dbl_read++;
        prev_read = bus.read_audio_in;
    end

    // Offers one pair and returns on the negedge where sample_valid is seen.
    task automatic do_pair(input logic [31:0] l, input logic [31:0] r, output bit ok);
        bus.left_channel_audio_in  = l;
        bus.right_channel_audio_in = r;
        bus.audio_in_available     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (bus.sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
        bus.audio_in_available = 1'b0;
    endtask

    task automatic test_reset();
        bus.audio_in_available     = 1'b0;
        bus.left_channel_audio_in  = '0;
        bus.right_channel_audio_in = '0;
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        n_cmp++;
        if (bus.read_audio_in !== 1'b0) begin
            n_err++; $display("FAIL reset_read: got %b expected 0", bus.read_audio_in);
        end
        n_cmp++;
        if ({bus.sample_valid, bus.sound_active, bus.sound_event} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 000",
                              {bus.sample_valid, bus.sound_active, bus.sound_event});
        end
        n_cmp++;
        if (bus.mag_out !== 16'h0000) begin
            n_err++; $display("FAIL reset_mag: got %h expected 0000", bus.mag_out);
        end
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_pop_rate();
        int pulses  = 0;
        int gap_err = 0;
        int last    = -1;
        bus.left_channel_audio_in  = 32'h1000_0000;
        bus.right_channel_audio_in = 32'hF000_0000;
        bus.audio_in_available     = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge CLOCK_50);
            if (bus.read_audio_in) begin
                pulses++;
                if (last >= 0 && (cyc - last) != 4) gap_err++;
                last = cyc;
            end
        end
        bus.audio_in_available = 1'b0;
        n_cmp++;
        if (pulses !== 4) begin
            n_err++; $display("FAIL pop_count: got %0d expected 4", pulses);
        end
        n_cmp++;
        if (gap_err !== 0) begin
            n_err++; $display("FAIL pop_spacing: got %0d bad gaps expected 0", gap_err);
        end
        n_cmp++;
        if (bus.mag_out !== 16'h1000) begin
            n_err++; $display("FAIL pop_mag: got %h expected 1000", bus.mag_out);
        end
        n_cmp++;
        if (bus.sound_active !== 1'b0) begin
            n_err++; $display("FAIL pop_active: got %b expected 0", bus.sound_active);
        end
        repeat (8) @(negedge CLOCK_50);
    endtask

    task automatic test_onset();
        bit ok;
        int ev0 = ev_cnt;
        do_pair(32'h3000_0000, 32'h0000_0000, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++; $display("FAIL onset_timeout: got %b expected 1", ok);
        end
        n_cmp++;
        if ({bus.sound_event, bus.sound_active} !== 2'b11) begin
            n_err++; $display("FAIL onset_flags: got %b expected 11",
                              {bus.sound_event, bus.sound_active});
        end
        n_cmp++;
        if (bus.mag_out !== 16'h3000) begin
            n_err++; $display("FAIL onset_mag: got %h expected 3000", bus.mag_out);
        end
        @(negedge CLOCK_50);
        n_cmp++;
        if (bus.sound_event !== 1'b0) begin
            n_err++; $display("FAIL onset_pulse_width: got %b expected 0", bus.sound_event);
        end
        repeat (2) @(negedge CLOCK_50);
        n_cmp++;
        if (ev_cnt !== ev0 + 1) begin
            n_err++; $display("FAIL onset_event_count: got %0d expected %0d", ev_cnt, ev0 + 1);
        end
    endtask

    task automatic test_quiet_release();
        bit ok;
        int tmo   = 0;
        int early = 0;
        int ev0   = ev_cnt;
        for (int k = 0; k < 4799; k++) begin
            do_pair(32'h0, 32'h0, ok);
            if (!ok) tmo++;
            if (bus.sound_active !== 1'b1) early++;
        end
        n_cmp++;
        if (tmo !== 0) begin
            n_err++; $display("FAIL quiet_timeout: got %0d timeouts expected 0", tmo);
        end
        n_cmp++;
        if (early !== 0) begin
            n_err++; $display("FAIL quiet_4799_active: got %0d early drops expected 0", early);
        end
        do_pair(32'h0, 32'h0, ok);
        n_cmp++;
        if ({ok, bus.sound_active, bus.sound_event} !== 3'b100) begin
            n_err++; $display("FAIL quiet_4800_release: got ok/act/ev %b expected 100",
                              {ok, bus.sound_active, bus.sound_event});
        end
        repeat (2) @(negedge CLOCK_50);
        n_cmp++;
        if (ev_cnt !== ev0) begin
            n_err++; $display("FAIL quiet_no_event: got %0d expected %0d", ev_cnt, ev0);
        end
    endtask

    task automatic test_hold();
        bit ok;
        int tmo   = 0;
        int early = 0;
        int ev0   = ev_cnt;
        do_pair(32'h3000_0000, 32'h0, ok);
        n_cmp++;
        if ({ok, bus.sound_event} !== 2'b11) begin
            n_err++; $display("FAIL hold_reactivate: got ok/ev %b expected 11", {ok, bus.sound_event});
        end
        for (int k = 0; k < 4000; k++) begin
            do_pair(32'h0, 32'h0, ok);
            if (!ok) tmo++;
        end
        do_pair(32'h1800_0000, 32'h0, ok);
        n_cmp++;
        if (bus.mag_out !== 16'h1800) begin
            n_err++; $display("FAIL hold_mid_mag: got %h expected 1800", bus.mag_out);
        end
        for (int k = 0; k < 4000; k++) begin
            do_pair(32'h0, 32'h0, ok);
            if (!ok) tmo++;
            if (bus.sound_active !== 1'b1) early++;
        end
        n_cmp++;
        if ({tmo, early} !== 64'd0) begin
            n_err++; $display("FAIL hold_active: got %0d timeouts %0d drops expected 0 0", tmo, early);
        end
        repeat (2) @(negedge CLOCK_50);
        n_cmp++;
        if (ev_cnt !== ev0 + 1) begin
            n_err++; $display("FAIL hold_single_event: got %0d expected %0d", ev_cnt, ev0 + 1);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        do_pair(32'h8000_0000, 32'hFFFF_0000, ok);
        n_cmp++;
        if (bus.mag_out !== 16'h7FFF) begin
            n_err++; $display("FAIL sat_most_neg: got %h expected 7fff", bus.mag_out);
        end
        do_pair(32'h0000_0000, 32'hFFFF_0000, ok);
        n_cmp++;
        if (bus.mag_out !== 16'h0001) begin
            n_err++; $display("FAIL sat_minus_one: got %h expected 0001", bus.mag_out);
        end
        do_pair(32'h0000_0000, 32'h8001_0000, ok);
        n_cmp++;
        if (bus.mag_out !== 16'h7FFF) begin
            n_err++; $display("FAIL sat_right_wins: got %h expected 7fff", bus.mag_out);
        end
        do_pair(32'h0000_FFFF, 32'h0001_0000, ok);
        n_cmp++;
        if (bus.mag_out !== 16'h0001) begin
            n_err++; $display("FAIL sat_low_bits_ignored: got %h expected 0001", bus.mag_out);
        end
    endtask

    task automatic test_reset_in_read();
        bit ok;
        bit seen = 1'b0;
        n_cmp++;
        if (bus.sound_active !== 1'b1) begin
            n_err++; $display("FAIL rst_pre_active: got %b expected 1", bus.sound_active);
        end
        bus.left_channel_audio_in  = 32'h2000_0000;
        bus.right_channel_audio_in = 32'h0;
        bus.audio_in_available     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (bus.read_audio_in) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_err++; $display("FAIL rst_read_seen: got %b expected 1", seen);
        end
        reset = 1'b1;
        @(negedge CLOCK_50);
        n_cmp++;
        if ({bus.read_audio_in, bus.sample_valid, bus.sound_active, bus.sound_event} !== 4'b0000) begin
            n_err++; $display("FAIL rst_in_read_flags: got %b expected 0000",
                              {bus.read_audio_in, bus.sample_valid, bus.sound_active, bus.sound_event});
        end
        n_cmp++;
        if (bus.mag_out !== 16'h0000) begin
            n_err++; $display("FAIL rst_in_read_mag: got %h expected 0000", bus.mag_out);
        end
        reset = 1'b0;
        do_pair(32'h2000_0000, 32'h0, ok);
        n_cmp++;
        if ({ok, bus.sound_event, bus.sound_active} !== 3'b111) begin
            n_err++; $display("FAIL rst_resume_flags: got ok/ev/act %b expected 111",
                              {ok, bus.sound_event, bus.sound_active});
        end
        n_cmp++;
        if (bus.mag_out !== 16'h2000) begin
            n_err++; $display("FAIL rst_resume_mag: got %h expected 2000", bus.mag_out);
        end
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (dbl_read !== 0) begin
            n_err++; $display("FAIL back_to_back_read: got %0d expected 0", dbl_read);
        end
        n_cmp++;
        if (orphan_ev !== 0) begin
            n_err++; $display("FAIL event_without_valid: got %0d expected 0", orphan_ev);
        end
    endtask

    initial begin
        test_reset();
        test_pop_rate();
        test_onset();
        test_quiet_release();
        test_hold();
        test_saturation();
        test_reset_in_read();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
